knapsack_input_loader: RTL and testbench
========================================

Name: knapsack_input_loader

Overview:
- Front-end entry sequencer for the knapsack circuit.
- Turns operator switch values and button levels into a committed problem description: item count N, capacity W, weight[i] and price[i].
- Feeds the solver through a valid/ack handshake.
- Drives field/index/value status outputs for the downstream 7-segment display driver.

Parameters:
MAX_N, 8, maximum item count; also the number of weight/price slots.
VAL_W, 4, width of sw and of every stored value.
IDX_W, 3, width of item index; must satisfy 2**IDX_W >= MAX_N.

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  synchronous active-low reset
in_signal_c  input  1  capture button level, debounced, synchronous to clk
in_signal_r  input  1  commit/advance button level, debounced, synchronous
in_signal_u  input  1  soft clear button level, debounced, synchronous
sw  input  VAL_W  switch value
solver_ack_i  input  1  solver has accepted the loaded problem
load_valid_o  output  1  problem complete and stable
n_o  output  IDX_W+1  committed item count
cap_o  output  VAL_W  committed capacity W
weights_o  output  MAX_N*VAL_W  weight[i] at bits [VAL_W*i +: VAL_W]
prices_o  output  MAX_N*VAL_W  price[i], same packing
field_o  output  3  0=N, 1=W, 2=weight, 3=price, 4=ready, 5=done, 7=error
index_o  output  IDX_W  current item index (0 outside weight/price states)
value_o  output  VAL_W  staged value
staged_o  output  1  a staged value is pending commit
err_o  output  1  invalid N was committed

Behaviour:
- Clock is clk; reset is synchronous and active-low.
- rst_n=0 at a rising edge forces:
  - state S_N.
  - all outputs and arrays to 0.
  - prev-sample registers of c/r/u to 1, so a button held through reset yields no edge.
- Edge pulses are combinational: pulse = level & ~prev; prev <= level every cycle.
- An action takes effect at the same clock edge where the level is first sampled 1; outputs reflect it one cycle after that sample.
- Priority per cycle: u edge > r edge > c edge. When r and c edges coincide, c is ignored.
- u edge, any state:
  - return to S_N.
  - clear arrays, n, cap, staged, err and load_valid.
- c edge, states S_N/S_W/S_WI/S_PI: staged_q <= sw; staged_o <= 1. A repeated c overwrites the staged value. c is ignored in S_READY, S_DONE and S_ERR.
- r edge with staged_o=0: ignored, no state change.
- r edge with staged_o=1: commit staged_q, clear staged_o, then transition by state:
  - S_N:
    - value 0 or value > MAX_N -> S_ERR, err_o=1.
    - otherwise n_o <= value -> S_W.
  - S_W: cap_o <= value (0 legal); idx <= 0 -> S_WI.
  - S_WI: weight[idx] <= value.
    - idx == n-1 -> idx <= 0, S_PI.
    - otherwise idx++.
  - S_PI: price[idx] <= value.
    - idx == n-1 -> S_READY.
    - otherwise idx++.
- S_READY:
  - load_valid_o=1, with all data outputs frozen.
  - solver_ack_i=1 -> S_DONE, load_valid_o=0 next cycle.
  - ack while not in S_READY is ignored.
- S_DONE: holds all data outputs. Only a u edge or rst_n exits.
- S_ERR: holds err_o=1. Only a u edge or rst_n exits; c/r are ignored.
- Slots with i >= n stay 0.
- value_o mirrors staged_q. staged_q is 0 after reset, clear, or commit.
- field_o encodes the current state as listed in Ports.

Test Plan:
- Reset / no-edge: hold in_signal_c=1 during rst_n=0, then release reset with c still 1 -> staged_o stays 0 and field_o=0.
- Full load: enter N=4, W=10, weights 6,4,4,2, prices 15,4,6,1, each as c pulse then r pulse, then ack:
  - after the final r -> field_o=4, load_valid_o=1, n_o=4, cap_o=10.
  - weights_o: slot0=6, slot1=4, slot2=4, slot3=2, slots 4-7 = 0.
  - prices_o: slot0=15, slot1=4, slot2=6, slot3=1.
  - then solver_ack_i=1 for 1 cycle -> field_o=5, load_valid_o=0, data unchanged.
- Invalid N:
  - sw=12, c, r -> field_o=7, err_o=1.
  - further c/r do nothing.
  - u pulse -> field_o=0, err_o=0.
  - sw=0 committed as N -> also error.
- Commit without capture: in S_W, pulse r with staged_o=0 -> state, cap_o and index_o unchanged.
- Priority:
  - c and r rising in the same cycle with staged=3 and sw=9 -> 3 is committed, staged_o=0.
  - u coinciding with r -> clear wins, field_o=0.
- Mid-entry clear: after N=4, W=10, w0=6, pulse u -> all outputs 0, field_o=0. A subsequent N=2 load then works normally.

Source files
------------

// File: rtl/knapsack_input_loader.sv
// Operator entry sequencer for the knapsack solver: captures N, W, weight[i] and
// price[i] from switches and buttons, then offers the problem over valid/ack.
module knapsack_input_loader #(
  parameter int unsigned MAX_N = 8,
  parameter int unsigned VAL_W = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_signal_c,
  input  logic                     in_signal_r,
  input  logic                     in_signal_u,
  input  logic [VAL_W-1:0]         sw,
  input  logic                     solver_ack_i,
  output logic                     load_valid_o,
  output logic [IDX_W:0]           n_o,
  output logic [VAL_W-1:0]         cap_o,
  output logic [MAX_N*VAL_W-1:0]   weights_o,
  output logic [MAX_N*VAL_W-1:0]   prices_o,
  output logic [2:0]               field_o,
  output logic [IDX_W-1:0]         index_o,
  output logic [VAL_W-1:0]         value_o,
  output logic                     staged_o,
  output logic                     err_o
);

  // Encodings double as the field_o display code.
  typedef enum logic [2:0] {
    S_N     = 3'd0,
    S_W     = 3'd1,
    S_WI    = 3'd2,
    S_PI    = 3'd3,
    S_READY = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd7
  } state_t;

  localparam logic [VAL_W:0] MAX_N_V = (VAL_W+1)'(MAX_N);

  state_t                   state_q;
  logic                     prev_c_q, prev_r_q, prev_u_q;
  logic [IDX_W:0]           n_q;
  logic [VAL_W-1:0]         cap_q;
  logic [MAX_N*VAL_W-1:0]   weights_q, prices_q;
  logic [IDX_W-1:0]         idx_q;
  logic [VAL_W-1:0]         staged_q;
  logic                     staged_v_q;
  logic                     err_q;
  logic                     load_valid_q;

  logic c_edge, r_edge, u_edge;
  logic idx_last;
  logic n_ok;

  always_comb begin
    c_edge   = in_signal_c & ~prev_c_q;
    r_edge   = in_signal_r & ~prev_r_q;
    u_edge   = in_signal_u & ~prev_u_q;
    idx_last = ({1'b0, idx_q} == (n_q - (IDX_W+1)'(1)));
    n_ok     = (staged_q != '0) && ({1'b0, staged_q} <= MAX_N_V);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_N;
      prev_c_q     <= 1'b1;
      prev_r_q     <= 1'b1;
      prev_u_q     <= 1'b1;
      n_q          <= '0;
      cap_q        <= '0;
      weights_q    <= '0;
      prices_q     <= '0;
      idx_q        <= '0;
      staged_q     <= '0;
      staged_v_q   <= 1'b0;
      err_q        <= 1'b0;
      load_valid_q <= 1'b0;
    end else begin
      prev_c_q <= in_signal_c;
      prev_r_q <= in_signal_r;
      prev_u_q <= in_signal_u;

      if (u_edge) begin
        state_q      <= S_N;
        n_q          <= '0;
        cap_q        <= '0;
        weights_q    <= '0;
        prices_q     <= '0;
        idx_q        <= '0;
        staged_q     <= '0;
        staged_v_q   <= 1'b0;
        err_q        <= 1'b0;
        load_valid_q <= 1'b0;
      end else begin
        unique case (state_q)
          S_N, S_W, S_WI, S_PI: begin
            // A commit edge swallows a coincident capture edge even with nothing staged.
            if (r_edge) begin
              if (staged_v_q) begin
                staged_q   <= '0;
                staged_v_q <= 1'b0;
                unique case (state_q)
                  S_N: begin
                    if (n_ok) begin
                      n_q     <= (IDX_W+1)'(staged_q);
                      state_q <= S_W;
                    end else begin
                      err_q   <= 1'b1;
                      state_q <= S_ERR;
                    end
                  end
                  S_W: begin
                    cap_q   <= staged_q;
                    idx_q   <= '0;
                    state_q <= S_WI;
                  end
                  S_WI: begin
                    weights_q[VAL_W*idx_q +: VAL_W] <= staged_q;
                    if (idx_last) begin
                      idx_q   <= '0;
                      state_q <= S_PI;
                    end else begin
                      idx_q <= idx_q + IDX_W'(1);
                    end
                  end
                  S_PI: begin
                    prices_q[VAL_W*idx_q +: VAL_W] <= staged_q;
                    if (idx_last) begin
                      idx_q        <= '0;
                      load_valid_q <= 1'b1;
                      state_q      <= S_READY;
                    end else begin
                      idx_q <= idx_q + IDX_W'(1);
                    end
                  end
                  default: ;
                endcase
              end
            end else if (c_edge) begin
              staged_q   <= sw;
              staged_v_q <= 1'b1;
            end
          end
          S_READY: begin
            if (solver_ack_i) begin
              load_valid_q <= 1'b0;
              state_q      <= S_DONE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign load_valid_o = load_valid_q;
  assign n_o          = n_q;
  assign cap_o        = cap_q;
  assign weights_o    = weights_q;
  assign prices_o     = prices_q;
  assign field_o      = state_q;
  assign index_o      = idx_q;
  assign value_o      = staged_q;
  assign staged_o     = staged_v_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_knapsack_input_loader.sv
// Bench for knapsack_input_loader: directed scenarios plus random button/switch
// activity, all outputs compared every cycle against a field-level reference model.
module tb_knapsack_input_loader;

  localparam int MAX_N = 8;
  localparam int VAL_W = 4;
  localparam int IDX_W = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_n, c, r, u, ack;
  logic [VAL_W-1:0]       sw;
  logic                   load_valid_o, staged_o, err_o;
  logic [IDX_W:0]         n_o;
  logic [VAL_W-1:0]       cap_o, value_o;
  logic [MAX_N*VAL_W-1:0] weights_o, prices_o;
  logic [2:0]             field_o;
  logic [IDX_W-1:0]       index_o;

  knapsack_input_loader #(.MAX_N(MAX_N), .VAL_W(VAL_W), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_signal_c(c), .in_signal_r(r), .in_signal_u(u),
    .sw(sw), .solver_ack_i(ack),
    .load_valid_o(load_valid_o), .n_o(n_o), .cap_o(cap_o),
    .weights_o(weights_o), .prices_o(prices_o),
    .field_o(field_o), .index_o(index_o), .value_o(value_o),
    .staged_o(staged_o), .err_o(err_o)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: field code 0=N 1=W 2=weight 3=price 4=ready 5=done 7=error
  int m_field, m_n, m_cap, m_idx, m_stg;
  bit m_stgv, m_err, m_lv;
  int m_w[MAX_N];
  int m_p[MAX_N];
  bit pc, pr, pu;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_clear();
    m_field = 0; m_n = 0; m_cap = 0; m_idx = 0; m_stg = 0;
    m_stgv = 0; m_err = 0; m_lv = 0;
    for (int i = 0; i < MAX_N; i++) begin
      m_w[i] = 0;
      m_p[i] = 0;
    end
  endfunction

  function automatic void model_step();
    bit ec, er, eu;
    int v;
    if (!rst_n) begin
      model_clear();
      pc = 1; pr = 1; pu = 1;
      return;
    end
    ec = c & ~pc; er = r & ~pr; eu = u & ~pu;
    pc = c; pr = r; pu = u;
    if (eu) begin
      model_clear();
    end else if (m_field == 4) begin
      if (ack) begin
        m_field = 5;
        m_lv = 0;
      end
    end else if (m_field <= 3) begin
      if (er) begin
        if (m_stgv) begin
          v = m_stg;
          m_stg = 0;
          m_stgv = 0;
          case (m_field)
            0: if (v == 0 || v > MAX_N) begin m_field = 7; m_err = 1; end
               else begin m_n = v; m_field = 1; end
            1: begin m_cap = v; m_idx = 0; m_field = 2; end
            2: begin
              m_w[m_idx] = v;
              if (m_idx == m_n - 1) begin m_idx = 0; m_field = 3; end
              else m_idx++;
            end
            default: begin
              m_p[m_idx] = v;
              if (m_idx == m_n - 1) begin m_idx = 0; m_field = 4; m_lv = 1; end
              else m_idx++;
            end
          endcase
        end
      end else if (ec) begin
        m_stg = int'(sw);
        m_stgv = 1;
      end
    end
  endfunction

  task automatic compare_all();
    logic [MAX_N*VAL_W-1:0] ew, ep;
    for (int i = 0; i < MAX_N; i++) begin
      ew[VAL_W*i +: VAL_W] = VAL_W'(m_w[i]);
      ep[VAL_W*i +: VAL_W] = VAL_W'(m_p[i]);
    end
    check("field",      64'(field_o),      64'(m_field));
    check("load_valid", 64'(load_valid_o), 64'(m_lv));
    check("n",          64'(n_o),          64'(m_n));
    check("cap",        64'(cap_o),        64'(m_cap));
    check("weights",    64'(weights_o),    64'(ew));
    check("prices",     64'(prices_o),     64'(ep));
    check("index",      64'(index_o),      64'(m_idx));
    check("value",      64'(value_o),      64'(m_stg));
    check("staged",     64'(staged_o),     64'(m_stgv));
    check("err",        64'(err_o),        64'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic pulse_c(input int v);
    sw = VAL_W'(v); c = 1; step(); c = 0; step();
  endtask

  task automatic pulse_r();
    r = 1; step(); r = 0; step();
  endtask

  task automatic pulse_u();
    u = 1; step(); u = 0; step();
  endtask

  task automatic enter(input int v);
    pulse_c(v);
    pulse_r();
  endtask

  initial begin
    int ew[MAX_N];
    int ep[MAX_N];
    rst_n = 0; c = 0; r = 0; u = 0; ack = 0; sw = '0;
    model_clear();
    pc = 1; pr = 1; pu = 1;

    // Button held through reset must not register as an edge
    c = 1; step(); step();
    check("rst_field", 64'(field_o), 64'd0);
    check("rst_n_o", 64'(n_o), 64'd0);
    rst_n = 1; step();
    check("held_c_staged", 64'(staged_o), 64'd0);
    check("held_c_field", 64'(field_o), 64'd0);
    c = 0; step();

    // Full load then ack
    enter(4); enter(10);
    enter(6); enter(4); enter(4); enter(2);
    enter(15); enter(4); enter(6); enter(1);
    check("full_field", 64'(field_o), 64'd4);
    check("full_valid", 64'(load_valid_o), 64'd1);
    check("full_n", 64'(n_o), 64'd4);
    check("full_cap", 64'(cap_o), 64'd10);
    ew = '{6, 4, 4, 2, 0, 0, 0, 0};
    ep = '{15, 4, 6, 1, 0, 0, 0, 0};
    for (int i = 0; i < MAX_N; i++) begin
      check($sformatf("full_w%0d", i), 64'(weights_o[VAL_W*i +: VAL_W]), 64'(ew[i]));
      check($sformatf("full_p%0d", i), 64'(prices_o[VAL_W*i +: VAL_W]), 64'(ep[i]));
    end
    ack = 1; step(); ack = 0; step();
    check("done_field", 64'(field_o), 64'd5);
    check("done_valid", 64'(load_valid_o), 64'd0);
    check("done_w0", 64'(weights_o[3:0]), 64'd6);
    check("done_p0", 64'(prices_o[3:0]), 64'd15);
    pulse_u();

    // Invalid N values
    enter(12);
    check("badn_field", 64'(field_o), 64'd7);
    check("badn_err", 64'(err_o), 64'd1);
    enter(3);
    check("err_hold_field", 64'(field_o), 64'd7);
    check("err_hold_staged", 64'(staged_o), 64'd0);
    pulse_u();
    check("err_clr_field", 64'(field_o), 64'd0);
    check("err_clr_err", 64'(err_o), 64'd0);
    enter(0);
    check("zero_n_field", 64'(field_o), 64'd7);
    pulse_u();

    // Commit without capture in W
    enter(3);
    pulse_r();
    check("nocap_field", 64'(field_o), 64'd1);
    check("nocap_cap", 64'(cap_o), 64'd0);
    check("nocap_index", 64'(index_o), 64'd0);
    pulse_u();

    // r beats coincident c; u beats coincident r
    pulse_c(3);
    sw = 4'd9; c = 1; r = 1; step(); c = 0; r = 0; step();
    check("prio_n", 64'(n_o), 64'd3);
    check("prio_staged", 64'(staged_o), 64'd0);
    pulse_c(5);
    u = 1; r = 1; step(); u = 0; r = 0; step();
    check("u_over_r_field", 64'(field_o), 64'd0);
    check("u_over_r_cap", 64'(cap_o), 64'd0);

    // Mid-entry clear then a fresh N=2 load
    enter(4); enter(10); enter(6);
    pulse_u();
    check("mid_field", 64'(field_o), 64'd0);
    check("mid_weights", 64'(weights_o), 64'd0);
    check("mid_n", 64'(n_o), 64'd0);
    enter(2); enter(5); enter(1); enter(2); enter(3); enter(4);
    check("n2_field", 64'(field_o), 64'd4);
    check("n2_weights", 64'(weights_o), 64'h21);
    check("n2_prices", 64'(prices_o), 64'h43);

    // Random activity
    for (int k = 0; k < 4000; k++) begin
      rst_n = ($urandom_range(0, 599) != 0);
      c     = ($urandom_range(0, 2) == 0);
      r     = ($urandom_range(0, 2) == 0);
      u     = ($urandom_range(0, 59) == 0);
      ack   = ($urandom_range(0, 3) == 0);
      sw    = (m_field == 0) ? VAL_W'($urandom_range(0, 9)) : VAL_W'($urandom_range(0, 15));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
